gated_alu_unit: RTL
===================

// Module: gated_alu_unit
// PURPOSE
//  Parametrised successor to the fixed 16-bit clock-disabled ALU wrapper. Multi-cycle ALU with start/busy/done handshake.
//  Adds a sleep sequencer: drains any in-flight op, isolates outputs to CLAMP_VAL, then drops the clock enable.
//  Wake-up is timed. Drives an external ICG through clk_en; internal flops are also qualified by clk_en.
// PARAMETERS
//  WIDTH       16      operand/result width, >=4, power of 2
//  CLAMP_VAL   0       value driven on result while iso=1 (WIDTH bits)
//  WAKE_CYCLES 4       cycles clk_en is high before iso releases, >=1
// PORTS
//  clk        in   1      single clock
//  rst_n      in   1      asynchronous, active-low reset
//  a, b       in   WIDTH  operands, sampled on accepted start
//  opcode     in   4      operation, sampled on accepted start
//  start      in   1      request; accepted only in IDLE with sleep_req=0
//  busy       out  1      high from accept until the cycle done pulses
//  done       out  1      1-cycle pulse; result/err valid from this cycle
//  result     out  WIDTH  last result; CLAMP_VAL while iso=1
//  err        out  1      illegal opcode on last op (held with result)
//  sleep_req  in   1      level request to sleep; deassert to wake
//  sleep_ack  out  1      high while in SLEEP
//  clk_en     out  1      enable to the external ICG
//  iso        out  1      output isolation active
// BEHAVIOUR
//  Reset (async, any state): IDLE; result=0, err=0, busy=0, done=0, sleep_ack=0, clk_en=1, iso=0; mul counter=0.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (all mod 2^WIDTH); 5 SHL / 6 SHR by b[$clog2(WIDTH)-1:0], logical.
//   7 MUL: low WIDTH bits of a*b, shift-add; 8 LTU: result = (a<b) unsigned, zero-extended.
//   9-15: illegal; result=0, err=1, single-cycle timing.
//  Latency: single-cycle ops: done in the cycle after accept; MUL: done WIDTH cycles after accept.
//  States:
//   IDLE:  start&!sleep_req -> EXEC (or MUL); sleep_req -> ISO. With both high, sleep wins; start is dropped, no done.
//   EXEC:  1 cycle, update result/err, pulse done -> IDLE.
//   MUL:   WIDTH iterations; last iteration writes result and pulses done.
//          -> ISO if sleep_req, else IDLE.
//   ISO:   iso=1 for 1 cycle (clamp settles before the clock stops) -> SLEEP.
//   SLEEP: clk_en=0, sleep_ack=1, iso=1. !sleep_req -> WAKE.
//   WAKE:  clk_en=1, sleep_ack=0, iso=1; counts WAKE_CYCLES, then iso=0 -> IDLE.
//  Interactions:
//   start during busy/ISO/SLEEP/WAKE is ignored, with no error.
//   sleep_req during MUL does not abort; the op completes, done pulses, then ISO.
//   sleep_req re-asserted during WAKE: wake completes, IDLE then re-enters ISO.
//  Sequencer flops (state, wake counter) are never clock-gated; only datapath flops use clk_en.
//  Reset mid-op or mid-sleep: immediate return to reset values; partial MUL discarded.
// CONFIGURATION
//  ALU_RETAIN_EN defined: result/err registers keep their pre-sleep value; visible again once iso drops.
//  ALU_RETAIN_EN undefined: result/err cleared to 0 on ISO entry; after wake, result reads 0.
// STRUCTURE
//  Package gated_alu_pkg: alu_op_e enum (codes above), pwr_state_e enum (IDLE, EXEC, MUL, ISO, SLEEP, WAKE), opcode width constant.
//  Sub-module gated_alu_core: operand regs, combinational ops, iterative multiplier, result/err regs; has a clk_en qualifier.
//  Top gated_alu_unit: handshake/power FSM, wake counter, isolation mux.
// TESTING (WIDTH=16, CLAMP_VAL=16'hDEAD, WAKE_CYCLES=4)
//  1. ADD a=FFFF b=0002 -> done after 1 cycle, result=0001, err=0; opcode 12 -> result=0000, err=1.
//  2. MUL a=0123 b=0045 -> busy 16 cycles, done at cycle 16, result=4E6F; start mid-MUL ignored.
//  3. start and sleep_req in the same IDLE cycle -> no done, ISO next cycle, result=DEAD, then sleep_ack=1, clk_en=0.
//  4. sleep_req during MUL cycle 5 -> MUL completes (done), then ISO/SLEEP.
//     Drop sleep_req -> clk_en=1, iso=0 after 4 cycles.
//     result=4E6F with ALU_RETAIN_EN defined; 0000 without it.
//  5. rst_n low mid-MUL and mid-WAKE -> all outputs at reset values the same cycle, IDLE on release.
//  6. SHL a=0001 b=0013 (shift 3) -> 0008; LTU a=0003 b=0007 -> 0001; SUB 0000-0001 -> FFFF.

Source files
------------

// File: rtl/gated_alu_pkg.sv
// Shared types for the gated ALU: opcode encoding, power/handshake FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package gated_alu_pkg;

  localparam int OPCODE_W = 4;

  // Codes 9..15 are illegal and complete as single-cycle ops with err=1.
  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_LTU = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    ISO,
    SLEEP,
    WAKE
  } pwr_state_e;

endpackage

// File: rtl/gated_alu_core.sv
// ALU datapath: combinational ops, iterative shift-add multiplier, result/err regs.
// Latency: single-cycle ops land in result_q at the accept edge; MUL lands WIDTH-1 edges after accept.
// Backpressure: none; the controlling FSM only pulses accept when it can take an op.
// Ports: clk/rst_n; clk_en qualifies every flop here; accept loads an op; mul_step advances the
//   multiplier; iso_clear wipes result/err on sleep entry; result_q/err_q; mul_last flags the final MUL cycle.
// Config: ALU_RETAIN_EN keeps result/err across sleep instead of clearing them on ISO.
module gated_alu_core
  import gated_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                accept,
  input  logic                mul_step,
  input  logic                iso_clear,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    result_q,
  output logic                err_q,
  output logic                mul_last
);

`ifdef ALU_RETAIN_EN
  localparam bit CLEAR_ON_ISO = 1'b0;
`else
  localparam bit CLEAR_ON_ISO = 1'b1;
`endif

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] CNT_PEN  = SW'(WIDTH - 2);

  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [SW-1:0]    sh;

  assign sh = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << sh;
      OP_SHR:  alu_res = a >> sh;
      OP_MUL:  alu_res = '0;
      OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_ill = 1'b1;
    endcase
  end

  // Bit 0 of the multiplier is consumed at the accept edge, so the remaining
  // WIDTH-1 bits finish in time for result to be valid in the done cycle.
  assign addend   = mplier[0] ? mcand : '0;
  assign mul_sum  = acc + addend;
  assign mul_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (clk_en) begin
      if (accept) begin
        if (opcode == OP_MUL) begin
          acc    <= b[0] ? a : '0;
          mcand  <= a << 1;
          mplier <= b >> 1;
          cnt    <= '0;
        end else begin
          result_q <= alu_res;
          err_q    <= alu_ill;
        end
      end else if (mul_step) begin
        // cnt wraps back to 0 on the done cycle since WIDTH is a power of 2.
        cnt    <= cnt + SW'(1);
        acc    <= mul_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt == CNT_PEN) begin
          result_q <= mul_sum;
          err_q    <= 1'b0;
        end
      end else if (iso_clear && CLEAR_ON_ISO) begin
        result_q <= '0;
        err_q    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gated_alu_unit.sv
// Multi-cycle ALU with start/busy/done handshake and a drain/isolate/gate sleep sequencer.
// Latency: done 1 cycle after accept for single-cycle ops, WIDTH cycles for MUL; wake takes WAKE_CYCLES.
// Backpressure: start is only accepted in IDLE with sleep_req low; otherwise silently dropped.
// Ports: clk, rst_n; a/b/opcode/start in; busy/done/result/err out;
//   sleep_req in; sleep_ack/clk_en/iso out (clk_en drives the external ICG).
// Config: ALU_RETAIN_EN keeps result/err across sleep; default clears them on ISO entry.
module gated_alu_unit
  import gated_alu_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] CLAMP_VAL   = '0,
  parameter int               WAKE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                err,
  input  logic                sleep_req,
  output logic                sleep_ack,
  output logic                clk_en,
  output logic                iso
);

  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

  pwr_state_e       state;
  pwr_state_e       state_nxt;
  logic [WCW-1:0]   wake_cnt;
  logic [WCW-1:0]   wake_cnt_nxt;
  logic             accept;
  logic             mul_last;
  logic [WIDTH-1:0] result_q;

  // Sequencer flops run on the free clock: they must keep ticking in SLEEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wake_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wake_cnt_nxt = wake_cnt;
    accept       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    sleep_ack    = 1'b0;
    clk_en       = 1'b1;
    iso          = 1'b0;
    case (state)
      IDLE: begin
        // Sleep has priority; a simultaneous start is dropped.
        if (sleep_req) begin
          state_nxt = ISO;
        end else if (start) begin
          accept    = 1'b1;
          state_nxt = (opcode == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      MUL: begin
        busy = 1'b1;
        if (mul_last) begin
          done      = 1'b1;
          state_nxt = sleep_req ? ISO : IDLE;
        end
      end
      ISO: begin
        // One clamped cycle with the clock still running before gating.
        iso       = 1'b1;
        state_nxt = SLEEP;
      end
      SLEEP: begin
        iso       = 1'b1;
        clk_en    = 1'b0;
        sleep_ack = 1'b1;
        if (!sleep_req) begin
          state_nxt    = WAKE;
          wake_cnt_nxt = '0;
        end
      end
      WAKE: begin
        iso = 1'b1;
        if (wake_cnt == WAKE_LAST) begin
          state_nxt    = IDLE;
          wake_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt + WCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  gated_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .accept    (accept),
    .mul_step  (state == MUL),
    .iso_clear (state == ISO),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .result_q  (result_q),
    .err_q     (err),
    .mul_last  (mul_last)
  );

  assign result = iso ? CLAMP_VAL : result_q;

endmodule
